// File: rtl/mix_columns_seq.sv
// AES MixColumns / InvMixColumns engine. A 128-bit state is transformed
// COLS_PER_CYCLE columns per clock, with valid/ready handshakes on both sides.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    // Only divisors of four give whole column groups per cycle.
    if (!((COLS_PER_CYCLE == 1) || (COLS_PER_CYCLE == 2) || (COLS_PER_CYCLE == 4))) begin : g_bad_cols
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // col advances by COL_STEP (4 wraps to 0); LAST_COL is the start of the final group.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
    localparam logic [2:0] NUM_LANES = 3'(COLS_PER_CYCLE);

    // ---------------- GF(2^8) helpers ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // One column through the forward or inverse matrix; byte 0 is the MSB byte.
    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [7:0] a0, a1, a2, a3;
        logic [31:0] r;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        if (inv) begin
            r[31:24] = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
            r[23:16] = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
            r[15:8]  = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
            r[7:0]   = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
        end else begin
            r[31:24] = xtime(a0) ^ mul3(a1) ^ a2 ^ a3;
            r[23:16] = a0 ^ xtime(a1) ^ mul3(a2) ^ a3;
            r[15:8]  = a0 ^ a1 ^ xtime(a2) ^ mul3(a3);
            r[7:0]   = mul3(a0) ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    // Column 0 lives in the top 32 bits.
    function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] idx);
        logic [31:0] c;
        case (idx)
            2'd0:    c = s[127:96];
            2'd1:    c = s[95:64];
            2'd2:    c = s[63:32];
            2'd3:    c = s[31:0];
            default: c = 32'h0000_0000;
        endcase
        return c;
    endfunction

    // ---------------- state ----------------
    state_t       r_state;
    logic [127:0] r_work;
    logic         r_mode;
    logic [1:0]   r_col;
    logic         r_out_valid;
    logic [127:0] r_out_data;

    logic [31:0]  w_lane_out [4];
    logic [127:0] w_work_next;

    // One transform lane per column handled in a cycle; unused lane slots read as zero.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        if (g < COLS_PER_CYCLE) begin : g_active
            localparam logic [1:0] LANE = 2'(g);
            logic [1:0] w_idx;
            assign w_idx         = r_col + LANE;
            assign w_lane_out[g] = mix_col(get_col(r_work, w_idx), r_mode);
        end else begin : g_unused
            assign w_lane_out[g] = 32'h0000_0000;
        end
    end

    // Merge lane results into the work state; columns outside the current group are kept.
    always_comb begin
        logic [1:0] v_rel;
        v_rel       = 2'd0;
        w_work_next = r_work;
        for (int c = 0; c < 4; c++) begin
            v_rel = 2'(c) - r_col;
            if ({1'b0, v_rel} < NUM_LANES) begin
                w_work_next[127 - 32*c -: 32] = w_lane_out[v_rel];
            end else begin
                w_work_next[127 - 32*c -: 32] = get_col(r_work, 2'(c));
            end
        end
    end

    // Control FSM: load on accept, transform column groups, hold result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_work      <= 128'h0;
            r_mode      <= 1'b0;
            r_col       <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 128'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_work  <= in_data;
                        r_mode  <= in_inv;
                        r_col   <= 2'd0;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_work <= w_work_next;
                    r_col  <= r_col + COL_STEP;
                    if (r_col == LAST_COL) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_work_next;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (out_ready && in_valid) begin
                        // Output taken and next state loaded on the same edge.
                        r_work      <= in_data;
                        r_mode      <= in_inv;
                        r_col       <= 2'd0;
                        r_out_valid <= 1'b0;
                        r_state     <= ST_RUN;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready in IDLE, or in DONE exactly when the pending result is being taken.
    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: three instances (1, 2 and 4 columns
// per cycle) checked against fixed vectors and a generic GF(2^8) matrix model.
module tb_mix_columns_seq;

    logic         clk;
    logic         rst_n;
    logic [2:0]   iv;
    logic [2:0]   ir;
    logic [2:0]   inv;
    logic [2:0]   ov;
    logic [2:0]   ordy;
    logic [127:0] id [3];
    logic [127:0] od [3];

    int checks   = 0;
    int failures = 0;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        mix_columns_seq #(.COLS_PER_CYCLE((k == 0) ? 1 : ((k == 1) ? 2 : 4))) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[k]),
            .in_ready  (ir[k]),
            .in_inv    (inv[k]),
            .in_data   (id[k]),
            .out_valid (ov[k]),
            .out_ready (ordy[k]),
            .out_data  (od[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic m);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (m) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else   coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        res = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef[(j - r + 4) % 4], s[127 - 32*c - 8*j -: 8]);
                res[127 - 32*c - 8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic int n_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 2 : 1);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- comparison helpers ----------------
    task automatic chk128(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %032h expected %032h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Send one state to instance k, then wait for its result (returned at the first out_valid sample).
    task automatic run_one(input int k, input logic [127:0] d, input logic m,
                           output logic [127:0] res, output int lat);
        int w;
        id[k]  = d;
        inv[k] = m;
        iv[k]  = 1'b1;
        w = 0;
        while (!ir[k] && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk_int("accept_wait", int'(ir[k]), 1);
        @(posedge clk); #1;
        iv[k]  = 1'b0;
        inv[k] = ~m;          // must not affect the state already accepted
        id[k]  = rnd128();
        lat = 0;
        while (!ov[k] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = od[k];
    endtask

    typedef struct {
        int           k;
        logic         m;
        logic [127:0] din;
        logic [127:0] dexp;
    } vec_t;

    vec_t         tbl [4];
    logic [127:0] res, d1, d2, hold;
    int           lat;
    logic [127:0] q [$];
    int           cyc, n_acc, n_out, last_acc;
    logic         acc;

    initial begin
        tbl[0] = '{0, 1'b0, 128'hdb135345_f20a225c_01010101_2d26314c, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8};
        tbl[1] = '{2, 1'b1, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 128'hdb135345_f20a225c_01010101_2d26314c};
        tbl[2] = '{1, 1'b0, 128'hc6c6c6c6_d4d4d4d5_00000000_ffffffff, 128'hc6c6c6c6_d5d5d7d6_00000000_ffffffff};
        tbl[3] = '{1, 1'b1, 128'hc6c6c6c6_d5d5d7d6_00000000_ffffffff, 128'hc6c6c6c6_d4d4d4d5_00000000_ffffffff};

        rst_n = 1'b0;
        iv    = 3'b000;
        inv   = 3'b000;
        ordy  = 3'b111;
        for (int k = 0; k < 3; k++) id[k] = 128'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        for (int k = 0; k < 3; k++) begin
            chk_int("reset_out_valid", int'(ov[k]), 0);
            chk128("reset_out_data", od[k], 128'h0);
            chk_int("reset_in_ready", int'(ir[k]), 1);
        end

        // Known vectors with latency
        for (int i = 0; i < 4; i++) begin
            run_one(tbl[i].k, tbl[i].din, tbl[i].m, res, lat);
            chk128("vector_data", res, tbl[i].dexp);
            chk_int("vector_latency", lat, n_of(tbl[i].k));
            @(posedge clk); #1;
        end

        // Random vectors on every width against the model
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                d1 = rnd128();
                run_one(k, d1, 1'($urandom_range(0, 1)), res, lat);
                chk128("random_data", res, ref_mix(d1, ~inv[k]));
                chk_int("random_latency", lat, n_of(k));
                @(posedge clk); #1;
            end
        end

        // Backpressure on the 2-column instance
        ordy[1] = 1'b0;
        d1 = rnd128();
        run_one(1, d1, 1'b0, res, lat);
        chk128("bp_first_data", res, ref_mix(d1, 1'b0));
        hold = res;
        d2 = rnd128();
        id[1]  = d2;
        inv[1] = 1'b1;
        iv[1]  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk128("bp_hold_data", od[1], hold);
            chk_int("bp_in_ready", int'(ir[1]), 0);
            chk_int("bp_out_valid", int'(ov[1]), 1);
        end
        ordy[1] = 1'b1;
        #1;
        chk_int("bp_release_ready", int'(ir[1]), 1);
        @(posedge clk); #1;
        iv[1] = 1'b0;
        chk_int("bp_handshake_valid", int'(ov[1]), 0);
        lat = 0;
        while (!ov[1] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk_int("bp_pending_latency", lat, 2);
        chk128("bp_pending_data", od[1], ref_mix(d2, 1'b1));
        @(posedge clk); #1;

        // Back-to-back stream on the 1-column instance
        cyc = 0; n_acc = 0; n_out = 0; last_acc = 0;
        id[0]  = rnd128();
        inv[0] = 1'($urandom_range(0, 1));
        iv[0]  = 1'b1;
        while (n_out < 8 && cyc < 200) begin
            acc = iv[0] && ir[0];
            if (ov[0]) begin
                if (q.size() > 0) begin
                    chk128("b2b_data", od[0], q.pop_front());
                end else begin
                    chk_int("b2b_unexpected_output", 1, 0);
                end
                n_out++;
            end
            if (acc) begin
                q.push_back(ref_mix(id[0], inv[0]));
                if (n_acc > 0) chk_int("b2b_accept_spacing", cyc - last_acc, 5);
                last_acc = cyc;
                n_acc++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (n_acc < 8) begin
                    id[0]  = rnd128();
                    inv[0] = 1'($urandom_range(0, 1));
                end else begin
                    iv[0] = 1'b0;
                end
            end
        end
        iv[0] = 1'b0;
        chk_int("b2b_outputs", n_out, 8);
        chk_int("b2b_accepts", n_acc, 8);
        repeat (2) @(posedge clk);
        #1;

        // Reset during RUN on the 1-column instance
        id[0]  = rnd128();
        inv[0] = 1'b0;
        iv[0]  = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_int("rst_out_valid", int'(ov[0]), 0);
        chk128("rst_out_data", od[0], 128'h0);
        chk_int("rst_in_ready", int'(ir[0]), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        d1 = rnd128();
        run_one(0, d1, 1'b1, res, lat);
        chk128("post_rst_data", res, ref_mix(d1, 1'b1));
        chk_int("post_rst_latency", lat, 4);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
